// File: rtl/uart_pkg.sv
// Shared types and legal-range constants for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_mode_t;

    localparam int unsigned MIN_DATA_BITS   = 5;
    localparam int unsigned MAX_DATA_BITS   = 9;
    localparam int unsigned MIN_STOP_BITS   = 1;
    localparam int unsigned MAX_STOP_BITS   = 2;
    localparam int unsigned MAX_PARITY_MODE = 2;
    localparam int unsigned MIN_BAUD_DIV    = 2;

    // Wide enough to count up to MAX_DATA_BITS bits.
    localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses during the last cycle of every BAUD_DIV-cycle period;
// restart re-aligns the period so the following cycle is the first of a new bit.
module uart_baud_gen #(
    parameter int unsigned BAUD_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

    logic [CNT_W-1:0] cnt;

    // Tick is registered one count early so it lines up with the final cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else if (restart) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else begin
            cnt      <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            bit_tick <= (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding buffer.
// Define UART_TX_PARITY_EN to compile in the parity bit generator and PARITY state.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 frame_done
);

    localparam int unsigned BAUD_DIV = CLOCK_SPEED / BAUD_RATE;
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);

    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE > MAX_PARITY_MODE) begin : g_bad_parity_mode
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (BAUD_DIV < MIN_BAUD_DIV) begin : g_bad_baud_div
        $error("uart_tx_cfg: CLOCK_SPEED/BAUD_RATE must be at least 2");
    end

    tx_state_t              state, state_next;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0]   shreg, shreg_next;
    logic [DATA_BITS-1:0]   buf_data;
    logic                   buf_valid, buf_valid_next;
    logic                   tx_next;
    logic                   load;
    logic                   accept;
    logic                   bit_tick;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ON  = (PARITY_MODE != 32'(NONE));
    localparam logic PAR_ODD = (PARITY_MODE == 32'(ODD));
    logic par_bit, par_next;
`endif

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load),
        .bit_tick (bit_tick)
    );

    // Holding buffer: tx_ready mirrors "buffer empty" one cycle ahead.
    assign accept         = tx_valid & tx_ready;
    assign buf_valid_next = (buf_valid & ~load) | accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            tx_ready  <= 1'b1;
        end else begin
            buf_valid <= buf_valid_next;
            tx_ready  <= ~buf_valid_next;
            if (accept) begin
                buf_data <= tx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
            tx      <= tx_next;
            tx_busy <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
            par_bit <= par_next;
`endif
        end
    end

    // Next-state and next line-bit logic; tx_next is what the line shows next cycle.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        tx_next      = tx;
        load         = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next     = par_bit;
`endif

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                load    = buf_valid;
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    tx_next      = shreg[0];
                    shreg_next   = shreg >> 1;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        if (PAR_ON) begin
                            state_next = PARITY;
                            tx_next    = par_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                        tx_next      = shreg[0];
                        shreg_next   = shreg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next   = STOP;
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        load       = buf_valid;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Start a frame straight from the buffer; back-to-back frames get no idle bit.
        if (load) begin
            state_next   = START;
            tx_next      = 1'b0;
            shreg_next   = buf_data;
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            par_next     = PAR_ODD ? ~(^buf_data) : ^buf_data;
`endif
        end
    end

    // All terms are flops, so the pulse is aligned with the last stop-bit cycle.
    assign frame_done = (state == STOP) && (bit_cnt == STOP_LAST) && bit_tick;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have these parameters:
- CLOCK_SPEED, 50_000_000, input clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in bit/s.
- DATA_BITS, 8, payload width, legal 5..9.
- STOP_BITS, 1, stop-bit count, legal 1 or 2.
- PARITY_MODE, 0, parity selection: 0 none, 1 even, 2 odd.

REQ-002 The block SHALL have these ports, one clock, reset asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  payload word.
- tx_valid  in  1  payload offered.
- tx_ready  out  1  block accepts the word this cycle.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  a frame is on the line.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-003 BAUD_DIV SHALL equal CLOCK_SPEED/BAUD_RATE (integer truncation); every line bit SHALL last exactly BAUD_DIV clk cycles.
REQ-004 Frame order SHALL be: start bit (0); DATA_BITS payload bits, LSB first; optional parity bit; STOP_BITS stop bits (1).
REQ-005 A transfer SHALL occur when tx_valid and tx_ready are both high on a rising edge; tx_ready SHALL be registered and high exactly when the one-entry holding buffer is empty.
REQ-006 Once accepted, a word SHALL be captured, and later changes on tx_data SHALL NOT affect the frame being sent.
REQ-007 States SHALL be IDLE, START, DATA, PARITY and STOP.
- IDLE->START when the buffer holds a word.
- START->DATA after BAUD_DIV cycles.
- DATA->PARITY (or STOP when parity is absent) after DATA_BITS bit times.
- PARITY->STOP after one bit time.
- STOP->START (buffer full) or STOP->IDLE (buffer empty) after STOP_BITS bit times.
REQ-008 From IDLE, tx SHALL fall exactly 2 cycles after the accepting edge: buffer load, then move into the shift register.
REQ-009 Back-to-back frames SHALL have zero idle bits; the next start bit SHALL begin on the cycle after the last stop-bit cycle.
REQ-010 When a handshake and a buffer drain happen in the same cycle, the new word SHALL land in the buffer with no loss or duplication.
REQ-011 Parity bit values:
- Even parity SHALL be the XOR of the payload bits.
- Odd parity SHALL be its inverse.
REQ-012 tx SHALL be driven directly from a flop, with no combinational glitches.
REQ-013 tx_busy SHALL be high in START, DATA, PARITY and STOP.
REQ-014 frame_done SHALL pulse high on the final cycle of the last stop bit.
REQ-015 Elaboration SHALL fail with $error if DATA_BITS is outside 5..9, STOP_BITS is outside 1..2, PARITY_MODE exceeds 2, or BAUD_DIV is below 2.

Reset
REQ-016 While rst_n is low, the block SHALL immediately force these values:
- tx=1, tx_ready=1, tx_busy=0, frame_done=0.
- State IDLE, counters 0, buffer empty.
REQ-017 A reset asserted mid-frame SHALL abort the frame, return tx high asynchronously, and discard the buffered word.
REQ-018 The first handshake SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-019 With macro UART_TX_PARITY_EN defined, the PARITY state and parity generator SHALL be compiled in and SHALL follow PARITY_MODE.
REQ-020 Without UART_TX_PARITY_EN:
- The PARITY state and parity logic SHALL be absent.
- Frames SHALL carry no parity bit, and PARITY_MODE SHALL be ignored.

Structure
REQ-021 Package uart_pkg SHALL hold:
- the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
- the parity_mode_t enum (NONE=0, EVEN=1, ODD=2);
- the legal-range constants used in REQ-015.
REQ-022 Baud timing SHALL live in sub-module uart_baud_gen: parameter BAUD_DIV, inputs clk, rst_n and restart, output bit_tick, a one-cycle pulse every BAUD_DIV cycles.

Verification (bench parameters: CLOCK_SPEED=1000, BAUD_RATE=100, so BAUD_DIV=10)
REQ-023 8N1, send 0xA5 -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; frame_done pulses at cycle 100 of the frame.
REQ-024 UART_TX_PARITY_EN, 8 bits, even parity, send 0xA5 -> parity bit 0; with odd parity -> parity bit 1; frame is 11 bits (110 cycles).
REQ-025 DATA_BITS=7, STOP_BITS=2, even parity, send 0x41 -> tx reads 0,1,0,0,0,0,0,1,0,1,1, for 110 cycles.
REQ-026 8N1, tx_valid held high with 0x55 then 0x0F -> second start bit begins exactly 100 cycles after the first; tx_ready is low while the buffer is full; no idle bit between frames.
REQ-027 Pull rst_n low at cycle 35 of a frame with a word buffered -> tx=1 and tx_ready=1 immediately; after release with no new word, no frame is sent.
